// File: rtl/i2c_arb_pkg.sv
// Shared types, widths and helpers for the I2C requester arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package i2c_arb_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // Round-robin successor: the index after cur, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
    return (cur + 32'd1 >= n) ? 32'd0 : cur + 32'd1;
  endfunction

endpackage

// File: rtl/i2c_rr_picker.sv
// Round-robin picker: first set request bit at or after rr_ptr, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the result is used.
// Ports: req (request vector), rr_ptr (highest-priority index),
//        any_req (some request set), winner (selected index).
module i2c_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               any_req,
  output logic [ID_W-1:0]    winner
);

  logic [NUM_REQ-1:0] rot;
  int                 off;
  int                 sum;

  always_comb begin
    // Rotate so that bit 0 of rot is the requester at rr_ptr; the lowest
    // set bit of rot is then the distance from rr_ptr to the winner.
    rot = NUM_REQ'({req, req} >> rr_ptr);
    off = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    sum = off + int'(rr_ptr);
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    winner  = ID_W'(sum);
    any_req = |req;
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C master among NUM_REQ requesters with round-robin arbitration.
// Latency: request sampled in IDLE -> m_en and req_ready one cycle later; m_done -> rsp_valid one cycle later.
// Backpressure: requesters hold req_valid until their req_ready pulse; one transaction outstanding at a time.
// Ports: clk/reset_n; req_valid/req_wr_rdn/req_addr/req_wdata (per-requester
//        request, sliced per index); req_ready/rsp_valid (one-hot pulses),
//        rsp_rdata/rsp_err; m_en/m_wr_rdn/m_addr/m_wdata to the master,
//        m_rdata/m_done from the master; busy and grant_id status.
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_wr_rdn,
  input  logic [I2C_ADDR_W*NUM_REQ-1:0]    req_addr,
  input  logic [I2C_DATA_W*NUM_REQ-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [I2C_DATA_W-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             m_en,
  output logic                             m_wr_rdn,
  output logic [I2C_ADDR_W-1:0]            m_addr,
  output logic [I2C_DATA_W-1:0]            m_wdata,
  input  logic [I2C_DATA_W-1:0]            m_rdata,
  input  logic                             m_done,
  output logic                             busy,
  output logic [ID_W-1:0]                  grant_id
);

  localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_SAT  = '1;

  arb_state_t       state, state_nxt;
  logic [ID_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [TMR_W-1:0] timer, timer_nxt, timer_inc;

  logic [NUM_REQ-1:0]    req_ready_nxt, rsp_valid_nxt;
  logic [I2C_DATA_W-1:0] rsp_rdata_nxt, m_wdata_nxt;
  logic [I2C_ADDR_W-1:0] m_addr_nxt;
  logic                  rsp_err_nxt, m_en_nxt, m_wr_rdn_nxt, busy_nxt;
  logic [ID_W-1:0]       grant_nxt;

  logic            any_req;
  logic [ID_W-1:0] winner;

  i2c_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req     (req_valid),
    .rr_ptr  (rr_ptr),
    .any_req (any_req),
    .winner  (winner)
  );

  // Saturating increment: the timer never wraps back to zero.
  assign timer_inc = (timer == TMR_SAT) ? timer : timer + 1'b1;

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    timer_nxt     = timer;
    grant_nxt     = grant_id;
    req_ready_nxt = '0;
    rsp_valid_nxt = '0;
    rsp_rdata_nxt = '0;
    rsp_err_nxt   = 1'b0;
    m_en_nxt      = m_en;
    m_wr_rdn_nxt  = m_wr_rdn;
    m_addr_nxt    = m_addr;
    m_wdata_nxt   = m_wdata;

    case (state)
      IDLE: begin
        // Requests are only looked at here; m_done in IDLE is ignored.
        if (any_req) begin
          grant_nxt             = winner;
          m_wr_rdn_nxt          = req_wr_rdn[winner];
          m_addr_nxt            = req_addr[int'(winner)*I2C_ADDR_W +: I2C_ADDR_W];
          m_wdata_nxt           = req_wdata[int'(winner)*I2C_DATA_W +: I2C_DATA_W];
          req_ready_nxt[winner] = 1'b1;
          m_en_nxt              = 1'b1;
          timer_nxt             = '0;
          state_nxt             = BUSY;
        end
      end

      BUSY: begin
        // Done is tested first so it wins over a coincident timeout.
        if (m_done) begin
          rsp_valid_nxt[grant_id] = 1'b1;
          rsp_rdata_nxt           = m_wr_rdn ? '0 : m_rdata;
          m_en_nxt                = 1'b0;
          timer_nxt               = '0;
          state_nxt               = RELEASE;
        end else if (timer == TMR_LAST) begin
          rsp_valid_nxt[grant_id] = 1'b1;
          rsp_err_nxt             = 1'b1;
          m_en_nxt                = 1'b0;
          timer_nxt               = '0;
          state_nxt               = RELEASE;
        end else begin
          timer_nxt = timer_inc;
        end
      end

      RELEASE: begin
        // Wait for a level-style done to drop before re-arbitrating.
        m_en_nxt = 1'b0;
        if (!m_done || timer == TMR_LAST) begin
          rr_ptr_nxt = ID_W'(rr_next(32'(grant_id), NUM_REQ));
          timer_nxt  = '0;
          state_nxt  = IDLE;
        end else begin
          timer_nxt = timer_inc;
        end
      end

      default: begin
        m_en_nxt  = 1'b0;
        timer_nxt = '0;
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      timer     <= '0;
      grant_id  <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      m_en      <= 1'b0;
      m_wr_rdn  <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      timer     <= timer_nxt;
      grant_id  <= grant_nxt;
      req_ready <= req_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
      m_en      <= m_en_nxt;
      m_wr_rdn  <= m_wr_rdn_nxt;
      m_addr    <= m_addr_nxt;
      m_wdata   <= m_wdata_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule
